// File: rtl/mem_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and data access.
// Data wins ties; a watchdog aborts accesses the memory never acknowledges.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ready,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic            stall,
    output logic            err
);
    localparam int BW = DW / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            i_ready_q, i_ready_d;
    logic            d_ready_q, d_ready_d;
    logic            err_q, err_d;

    logic grant_d, grant_i, in_acc, timeout_hit, done;

    // A port in its ready cycle is masked so its still-high req cannot re-grant.
    assign grant_d     = (state_q == IDLE) && d_req && !d_ready_q;
    assign grant_i     = (state_q == IDLE) && !grant_d && i_req && !i_ready_q;
    assign in_acc      = (state_q != IDLE);
    assign timeout_hit = in_acc && !mem_ack && (cnt_q == TO_LAST);
    assign done        = in_acc && (mem_ack || timeout_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d)      state_d = D_ACC;
                else if (grant_i) state_d = I_ACC;
            end
            I_ACC, D_ACC: if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (grant_d) begin
                mem_req_d   = 1'b1;
                mem_we_d    = d_we;
                mem_be_d    = d_be;
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
            end else if (grant_i) begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b0;
                mem_be_d    = '0;
                mem_addr_d  = i_addr;
                mem_wdata_d = '0;
            end
        end else if (done) begin
            // An ack arriving on the last watchdog cycle still counts as a normal completion.
            mem_req_d = 1'b0;
            err_d     = !mem_ack;
            if (state_q == D_ACC) begin
                d_ready_d = 1'b1;
                d_rdata_d = mem_ack ? mem_rdata : '0;
            end else begin
                i_ready_d = 1'b1;
                i_rdata_d = mem_ack ? mem_rdata : '0;
            end
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign stall     = (i_req & ~i_ready_q) | (d_req & ~d_ready_q);
endmodule
